// File: rtl/disp_pkg.sv
// Shared constants and types for the seven-segment scan controller.
package disp_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] SEL_OFF   = 4'hF;

  // Indexed by slot; slot0 is the leftmost digit, then nibbles 0,1,2.
  localparam logic [3:0][3:0] SLOT_SEL = {4'b1011, 4'b1101, 4'b1110, 4'b0111};
  localparam logic [3:0][1:0] SLOT_NIB = {2'd2, 2'd1, 2'd0, 2'd3};

  // Active-low {g,f,e,d,c,b,a} for BCD 9..0.
  localparam logic [9:0][6:0] BCD_SEG = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic [3:0]  dp;
    logic [15:0] digits;
  } disp_val_t;

endpackage

// File: rtl/disp_scan_ctrl_seg7_decode.sv
// Combinational BCD to active-low segment decode; invalid codes and blank
// force all segments off while the decimal point is kept.
module seg7_decode
  import disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && (nibble <= 4'd9)) begin
      seg[6:0] = BCD_SEG[nibble];
    end
    seg[7] = ~dp;
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Four-digit common-anode scan controller with frame-synchronous double buffer.
// Build option: LEAD_ZERO_BLANK_EN blanks leading zero digits (nibble0 always shown).
//
//   state    | meaning
//   ST_BLANK | start of slot, all digits off to suppress ghosting
//   ST_SHOW  | current slot digit driven from the active buffer
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  output logic [3:0]  sel,
  output logic [7:0]  seg,
  output logic        upd_done,
  output logic        frame_tick
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       ptr;
  logic [0:0]       state;
  disp_val_t        shadow;
  disp_val_t        active;
  disp_val_t        load_val;
  logic             pending;
  logic [3:0]       sel_q;
  logic [7:0]       seg_q;
  logic             upd_q;

  logic             cnt_wrap;
  logic             commit;
  logic [1:0]       cur_idx;
  logic [3:0]       cur_nib;
  logic             cur_dp;
  logic [3:0]       lz;
  logic [7:0]       dec_seg;

  assign cnt_wrap   = (cnt == CNT_LAST);
  assign frame_tick = en && (ptr == 2'd3) && cnt_wrap;
  // While dark there is no frame to tear, so anything buffered goes straight through.
  assign commit     = frame_tick || !en;
  assign load_val   = {dp_in, data_in};

`ifdef LEAD_ZERO_BLANK_EN
  always_comb begin
    lz    = '0;
    lz[3] = (active.digits[15:12] == 4'd0);
    lz[2] = lz[3] && (active.digits[11:8] == 4'd0);
    lz[1] = lz[2] && (active.digits[7:4] == 4'd0);
  end
`else
  assign lz = '0;
`endif

  assign cur_idx = SLOT_NIB[ptr];
  assign cur_nib = active.digits[{cur_idx, 2'b00} +: 4];
  assign cur_dp  = active.dp[cur_idx];

  seg7_decode u_dec (
    .nibble (cur_nib),
    .dp     (cur_dp),
    .blank  (lz[cur_idx]),
    .seg    (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      ptr     <= '0;
      state   <= ST_BLANK;
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
      sel_q   <= SEL_OFF;
      seg_q   <= SEG_BLANK;
      upd_q   <= 1'b0;
    end else begin
      if (!en) begin
        cnt   <= '0;
        ptr   <= '0;
        state <= ST_BLANK;
      end else begin
        cnt <= cnt_wrap ? '0 : cnt + 1'b1;
        if (cnt_wrap) ptr <= ptr + 2'd1;
        if ((state == ST_BLANK) && (cnt == BLANK_LAST)) state <= ST_SHOW;
        else if ((state == ST_SHOW) && cnt_wrap)        state <= ST_BLANK;
      end

      if (en && (state == ST_SHOW)) begin
        sel_q <= SLOT_SEL[ptr];
        seg_q <= dec_seg;
      end else begin
        sel_q <= SEL_OFF;
        seg_q <= SEG_BLANK;
      end

      upd_q <= 1'b0;
      if (load) begin
        shadow <= load_val;
        if (commit) begin
          active  <= load_val;
          pending <= 1'b0;
          upd_q   <= 1'b1;
        end else begin
          pending <= 1'b1;
        end
      end else if (commit && pending) begin
        active  <= shadow;
        pending <= 1'b0;
        upd_q   <= 1'b1;
      end
    end
  end

  assign sel      = sel_q;
  assign seg      = seg_q;
  assign upd_done = upd_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl (CLK_DIV=8, BLANK_CYC=2); honours LEAD_ZERO_BLANK_EN.
module tb_disp_scan_ctrl;

  localparam int CLK_DIV   = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = 4 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  sel;
  logic [7:0]  seg;
  logic        upd_done;
  logic        frame_tick;

  always #5 clk = ~clk;

  disp_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .sel        (sel),
    .seg        (seg),
    .upd_done   (upd_done),
    .frame_tick (frame_tick)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int upd_count = 0;

  // Reference model: frame position 0..FRAME-1, buffers, expected registered outputs.
  int          m_pos = 0;
  logic [15:0] m_act = '0, m_sh = '0;
  logic [3:0]  m_act_dp = '0, m_sh_dp = '0;
  bit          m_pend = 0;
  logic [3:0]  e_sel = 4'hF;
  logic [7:0]  e_seg = 8'hFF;
  logic        e_upd = 1'b0;

  int         SLOT_NIB_T[4] = '{3, 0, 1, 2};
  logic [3:0] SLOT_SEL_T[4] = '{4'b0111, 4'b1110, 4'b1101, 4'b1011};
  logic [7:0] BCD_T[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                            8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  typedef struct {
    logic [15:0]     data;
    logic [3:0]      dp;
    logic [0:3][7:0] exp_seg;
  } vec_t;
  vec_t vecs[5];

  function automatic logic [7:0] ref_seg(input logic [15:0] v, input logic [3:0] dps, input int n);
    logic [7:0] s;
    int d;
    bit lead;
    d = int'(v[4*n +: 4]);
    lead = 0;
`ifdef LEAD_ZERO_BLANK_EN
    if (n != 0) begin
      lead = 1;
      for (int k = 3; k >= n; k--) if (v[4*k +: 4] != 4'd0) lead = 0;
    end
`endif
    s = (d <= 9 && !lead) ? BCD_T[d] : 8'hFF;
    if (dps[n]) s[7] = 1'b0;
    return s;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    bit ft, cm;
    int slot;
    @(posedge clk);
    if (rst) begin
      m_pos = 0; m_act = '0; m_act_dp = '0; m_sh = '0; m_sh_dp = '0; m_pend = 0;
      e_sel = 4'hF; e_seg = 8'hFF; e_upd = 1'b0;
    end else begin
      ft = en && (m_pos == FRAME - 1);
      cm = ft || !en;
      slot = m_pos / CLK_DIV;
      if (en && (m_pos % CLK_DIV) >= BLANK_CYC) begin
        e_sel = SLOT_SEL_T[slot];
        e_seg = ref_seg(m_act, m_act_dp, SLOT_NIB_T[slot]);
      end else begin
        e_sel = 4'hF;
        e_seg = 8'hFF;
      end
      e_upd = 1'b0;
      if (load && cm) begin
        m_act = data_in; m_act_dp = dp_in; m_pend = 0; e_upd = 1'b1;
      end else if (load) begin
        m_sh = data_in; m_sh_dp = dp_in; m_pend = 1;
      end else if (cm && m_pend) begin
        m_act = m_sh; m_act_dp = m_sh_dp; m_pend = 0; e_upd = 1'b1;
      end
      m_pos = en ? (m_pos + 1) % FRAME : 0;
    end
    #1;
    if (upd_done) upd_count++;
    chk("sel", 16'(sel), 16'(e_sel));
    chk("seg", 16'(seg), 16'(e_seg));
    chk("upd_done", 16'(upd_done), 16'(e_upd));
    chk("frame_tick", 16'(frame_tick), 16'(en && !rst && (m_pos == FRAME - 1)));
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    data_in = d;
    dp_in   = p;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  task automatic run_to(input int p);
    int g = 0;
    while (m_pos != p && g < 4 * FRAME) begin
      tick();
      g++;
    end
    if (m_pos != p) begin
      n_checks++;
      n_fail++;
      $display("FAIL run_to: position %0d expected %0d", m_pos, p);
    end
  endtask

  task automatic wait_upd(input int max_cyc);
    int g = 0;
    while (!upd_done && g < max_cyc) begin
      tick();
      g++;
    end
    chk("upd_wait", 16'(upd_done), 16'd1);
  endtask

  initial begin
    int t;
    vecs[0] = '{16'h1234, 4'b0000, {8'hF9, 8'h99, 8'hB0, 8'hA4}};
    vecs[1] = '{16'h5678, 4'b1000, {8'h12, 8'h80, 8'hF8, 8'h82}};
    vecs[2] = '{16'h900A, 4'b0001, {8'h90, 8'h7F, 8'hC0, 8'hC0}};
`ifdef LEAD_ZERO_BLANK_EN
    vecs[3] = '{16'h0040, 4'b0000, {8'hFF, 8'hC0, 8'h99, 8'hFF}};
    vecs[4] = '{16'h0000, 4'b1111, {8'h7F, 8'h40, 8'h7F, 8'h7F}};
`else
    vecs[3] = '{16'h0040, 4'b0000, {8'hC0, 8'hC0, 8'h99, 8'hC0}};
    vecs[4] = '{16'h0000, 4'b1111, {8'h40, 8'h40, 8'h40, 8'h40}};
`endif

    rst = 1'b1;
    tick();
    tick();
    chk("reset_sel", 16'(sel), 16'hF);
    chk("reset_seg", 16'(seg), 16'hFF);
    chk("reset_upd", 16'(upd_done), 16'd0);

    // First frame after reset still shows the zero active value; commit at frame end.
    rst = 1'b0;
    en  = 1'b1;
    do_load(16'h1234, 4'b0000);
    t = 1;
    while (!upd_done && t < 40) begin
      tick();
      t++;
`ifdef LEAD_ZERO_BLANK_EN
      if (t == 5) chk("frame0_slot0", 16'(seg), 16'hFF);
`else
      if (t == 5) chk("frame0_slot0", 16'(seg), 16'hC0);
`endif
    end
    chk("first_commit_cycle", 16'(t), 16'd32);

    foreach (vecs[i]) begin
      do_load(vecs[i].data, vecs[i].dp);
      wait_upd(2 * FRAME);
      for (int s = 0; s < 4; s++) begin
        repeat ((s == 0) ? 5 : CLK_DIV) tick();
        chk($sformatf("vec%0d_sel%0d", i, s), 16'(sel), 16'(SLOT_SEL_T[s]));
        chk($sformatf("vec%0d_seg%0d", i, s), 16'(seg), 16'(vecs[i].exp_seg[s]));
      end
    end

    // Two loads in one frame, then a load on the frame_tick cycle itself.
    run_to(0);
    upd_count = 0;
    run_to(3);
    do_load(16'h5678, 4'b0000);
    run_to(10);
    do_load(16'h5678, 4'b0000);
    run_to(FRAME - 1);
    do_load(16'h9999, 4'b0000);
    chk("tick_load_upd", 16'(upd_done), 16'd1);
    repeat (FRAME) tick();
    chk("multi_load_upd_count", 16'(upd_count), 16'd1);
    run_to(5);
    chk("after_9999_seg", 16'(seg), 16'h90);

    // Disable mid-SHOW with a pending value, then re-enable.
    run_to(12);
    do_load(16'h4321, 4'b0000);
    en = 1'b0;
    tick();
    chk("dis_sel", 16'(sel), 16'hF);
    chk("dis_seg", 16'(seg), 16'hFF);
    chk("dis_upd", 16'(upd_done), 16'd1);
    repeat (3) tick();
    en = 1'b1;
    tick();
    tick();
    chk("reen_blank_sel", 16'(sel), 16'hF);
    tick();
    chk("reen_show_sel", 16'(sel), 16'b0111);
    chk("reen_show_seg", 16'(seg), 16'h99);

    // Reset during slot2 with a pending value.
    run_to(18);
    do_load(16'h1111, 4'b0000);
    rst = 1'b1;
    tick();
    chk("midrst_sel", 16'(sel), 16'hF);
    chk("midrst_seg", 16'(seg), 16'hFF);
    chk("midrst_upd", 16'(upd_done), 16'd0);
    rst = 1'b0;
    upd_count = 0;
    repeat (40) tick();
    chk("midrst_no_upd", 16'(upd_count), 16'd0);

    // Random traffic against the model.
    repeat (1500) begin
      rst  = ($urandom_range(0, 299) == 0);
      en   = ($urandom_range(0, 19) != 0);
      load = ($urandom_range(0, 11) == 0);
      for (int k = 0; k < 4; k++)
        data_in[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 11));
      dp_in = 4'($urandom_range(0, 15));
      tick();
    end
    rst  = 1'b0;
    load = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
